// File: rtl/delay_line_pkg.sv
// Shared types and helpers for the circular-buffer delay line.
// Holds the controller state encoding and the delay range check.
package delay_line_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    // Forces a delay into the legal 1..2^aw-1 window.
    function automatic int clamp_delay(input int aw, input int d);
        int hi;
        hi = (1 << aw) - 1;
        if (d < 1) return 1;
        if (d > hi) return hi;
        return d;
    endfunction

endpackage

// File: rtl/delay_line_ctrl_if.sv
// Sample stream plus delay configuration bundle.
// master drives samples/config, slave is the delay line.
interface delay_line_ctrl_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] cfg_delay;
    logic                  cfg_load;
    logic                  cfg_ready;
    logic                  ivalid;
    logic [WIDTH-1:0]      idata;
    logic                  iready;
    logic                  ovalid;
    logic [WIDTH-1:0]      odata;
    logic [ADDR_WIDTH-1:0] cur_delay;

    modport master (
        output cfg_delay, cfg_load, ivalid, idata,
        input  cfg_ready, iready, ovalid, odata, cur_delay
    );

    modport slave (
        input  cfg_delay, cfg_load, ivalid, idata,
        output cfg_ready, iready, ovalid, odata, cur_delay
    );
endinterface

// File: rtl/sdp_ram.sv
// Simple dual-port RAM, one write and one registered read port.
// Array is never cleared; only the read register resets.
module sdp_ram #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);
    logic [WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clock) begin
        if (reset) rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/delay_line_ctrl.sv
// Delay line controller: circular buffer delaying a stream by D accepts.
// Reconfiguring D costs one flush cycle and restarts the fill.
module delay_line_ctrl
    import delay_line_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int ADDR_WIDTH    = 5,
    parameter int DEFAULT_DELAY = 2
) (
    input logic              clock,
    input logic              reset,
    delay_line_ctrl_if.slave bus
);
    localparam logic [ADDR_WIDTH-1:0] RST_DLY =
        ADDR_WIDTH'(clamp_delay(ADDR_WIDTH, DEFAULT_DELAY));

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] dly_q, dly_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] fill_q, fill_d;
    logic                  ovalid_q, ovalid_d;

    logic                  rdy;
    logic                  accept;
    logic                  load;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] fill_inc;
    logic [ADDR_WIDTH-1:0] cfg_dly;
    logic [WIDTH-1:0]      rdata;

    assign rdy      = (state_q != FLUSH);
    assign accept   = bus.ivalid & rdy;
    assign load     = bus.cfg_load & rdy;
    assign fill_inc = fill_q + 1'b1;
    assign rd_addr  = wr_ptr_q - dly_q;
    assign cfg_dly  =
        ADDR_WIDTH'(clamp_delay(ADDR_WIDTH, int'(bus.cfg_delay)));

    always_comb begin
        state_d  = state_q;
        dly_d    = dly_q;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        ovalid_d = 1'b0;
        rd_en    = 1'b0;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (fill_q < dly_q) fill_d = fill_inc;
        end

        unique case (state_q)
            FILL: begin
                if (load) begin
                    dly_d   = cfg_dly;
                    state_d = FLUSH;
                end else if (accept && fill_inc == dly_q) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (load) begin
                    dly_d   = cfg_dly;
                    state_d = FLUSH;
                end else if (accept) begin
                    ovalid_d = 1'b1;
                    rd_en    = 1'b1;
                end
            end
            FLUSH: begin
                wr_ptr_d = '0;
                fill_d   = '0;
                state_d  = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= FILL;
            dly_q    <= RST_DLY;
            wr_ptr_q <= '0;
            fill_q   <= '0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dly_q    <= dly_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            ovalid_q <= ovalid_d;
        end
    end

    sdp_ram #(
        .WIDTH     (WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clock  (clock),
        .reset  (reset),
        .we_i   (accept),
        .waddr_i(wr_ptr_q),
        .wdata_i(bus.idata),
        .re_i   (rd_en),
        .raddr_i(rd_addr),
        .rdata_o(rdata)
    );

    assign bus.iready    = rdy;
    assign bus.cfg_ready = rdy;
    assign bus.ovalid    = ovalid_q;
    assign bus.odata     = rdata;
    assign bus.cur_delay = dly_q;
endmodule

// File: tb/tb_delay_line_ctrl.sv
// Scoreboard bench for delay_line_ctrl: driver pushes expected
// samples, a negedge monitor pops them when ovalid fires.
module tb_delay_line_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    delay_line_ctrl_if #(.WIDTH(32), .ADDR_WIDTH(5)) bus ();

    delay_line_ctrl #(
        .WIDTH        (32),
        .ADDR_WIDTH   (5),
        .DEFAULT_DELAY(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    exp_t        me;
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_on = 1'b0;
    int          m_d    = 2;
    int          m_fill = 0;
    bit          m_flush = 1'b0;
    logic [31:0] hist[$];
    logic [31:0] last_out = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (mon_on) begin
            if (bus.ovalid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ovalid: unexpected odata=%0h at cycle %0d, none expected",
                             bus.odata, cyc);
                end else begin
                    me = sb.pop_front();
                    chk("odata", bus.odata, me.data);
                    chk("ovalid_cycle", 32'(cyc), 32'(me.cyc));
                end
            end
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                me = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_ovalid: none at cycle %0d, expected odata=%0h",
                         me.cyc, me.data);
            end
        end
    end

    // One clock: drive at negedge, update model, wait next negedge.
    task automatic step(input bit v, input logic [31:0] d,
                        input bit ld, input logic [4:0] cd);
        bit   acc;
        bit   lda;
        bit   gap_run;
        exp_t e;
        chk("iready", 32'(bus.iready), 32'(!m_flush));
        chk("cfg_ready", 32'(bus.cfg_ready), 32'(!m_flush));
        bus.ivalid    = v;
        bus.idata     = d;
        bus.cfg_load  = ld;
        bus.cfg_delay = cd;
        acc     = v && !m_flush;
        lda     = ld && !m_flush;
        gap_run = !v && !ld && !m_flush && (m_fill == m_d);
        if (acc && !lda && m_fill == m_d) begin
            e.cyc  = cyc + 1;
            e.data = hist[hist.size() - m_d];
            sb.push_back(e);
            last_out = e.data;
        end
        if (acc) begin
            hist.push_back(d);
            if (m_fill < m_d) m_fill++;
        end
        if (m_flush) begin
            m_flush = 1'b0;
            m_fill  = 0;
            hist.delete();
        end
        if (lda) begin
            m_d     = (cd == 5'd0) ? 1 : int'(cd);
            m_flush = 1'b1;
        end
        @(negedge clock);
        if (gap_run) chk("gap_odata_hold", bus.odata, last_out);
        bus.ivalid   = 1'b0;
        bus.cfg_load = 1'b0;
    endtask

    task automatic do_reset(input bit busy);
        bus.ivalid   = busy;
        bus.idata    = 32'hDEAD_BEEF;
        bus.cfg_load = 1'b0;
        reset        = 1'b1;
        @(negedge clock);
        chk("rst_ovalid", 32'(bus.ovalid), 32'd0);
        chk("rst_odata", bus.odata, 32'd0);
        chk("rst_iready", 32'(bus.iready), 32'd1);
        chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        chk("rst_cur_delay", 32'(bus.cur_delay), 32'd2);
        reset      = 1'b0;
        bus.ivalid = 1'b0;
        m_d        = 2;
        m_fill     = 0;
        m_flush    = 1'b0;
        last_out   = '0;
        hist.delete();
    endtask

    initial begin
        bus.ivalid    = 1'b0;
        bus.idata     = '0;
        bus.cfg_load  = 1'b0;
        bus.cfg_delay = '0;
        repeat (2) @(negedge clock);
        do_reset(1'b0);
        mon_on = 1'b1;

        // Continuous ramp at the default delay of 2.
        for (int i = 0; i < 10; i++) step(1'b1, 32'(i), 1'b0, 5'd0);

        // Reload to 4 on sample 10; sample 11 is offered during flush.
        step(1'b1, 32'd10, 1'b1, 5'd4);
        chk("cur_delay_4", 32'(bus.cur_delay), 32'd4);
        step(1'b1, 32'd11, 1'b0, 5'd0);
        for (int i = 11; i < 21; i++) step(1'b1, 32'(i), 1'b0, 5'd0);

        // Alternating ivalid while running.
        for (int i = 21; i < 27; i++) begin
            step(1'b1, 32'(i), 1'b0, 5'd0);
            step(1'b0, 32'hBAD0_0000, 1'b0, 5'd0);
        end

        // Zero delay request clamps to one.
        step(1'b0, 32'd0, 1'b1, 5'd0);
        chk("cur_delay_clamp", 32'(bus.cur_delay), 32'd1);
        step(1'b0, 32'd0, 1'b0, 5'd0);
        for (int i = 0; i < 6; i++) step(1'b1, 32'(200 + i), 1'b0, 5'd0);

        // Maximum delay with pointer wrap.
        step(1'b0, 32'd0, 1'b1, 5'd31);
        chk("cur_delay_31", 32'(bus.cur_delay), 32'd31);
        step(1'b0, 32'd0, 1'b0, 5'd0);
        for (int i = 0; i <= 40; i++) step(1'b1, 32'(i), 1'b0, 5'd0);

        // Reset in RUN with a live sample, then the default ramp again.
        do_reset(1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 32'(i), 1'b0, 5'd0);

        repeat (3) @(negedge clock);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
